// File: rtl/design01_mat_row_fetch.sv
// Row fetcher: streams word_count consecutive RAM words starting at base_addr
// through a first-word-fall-through buffer, framed with sop/eop and a done pulse.
module design01_mat_row_fetch #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } entry_t;

  state_t              state_q;
  state_t              state_d;

  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W:0]     remaining_q;
  logic                first_q;
  logic                inflight_q;
  logic                inflight_sop_q;
  logic                inflight_eop_q;
  logic                zero_done_q;

  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                accept_start;
  logic                zero_start;
  logic [RES_W-1:0]    reserved;
  logic                has_space;
  logic                issue;
  logic                last_issue;
  logic                push;
  logic                pop;
  logic                eop_pop;
  entry_t              head;

  assign accept_start = (state_q == IDLE) && start && (word_count != '0);
  assign zero_start   = (state_q == IDLE) && start && (word_count == '0);

  // A read is only issued when its returning word is guaranteed a FIFO slot,
  // counting words already buffered and the one still in flight from the RAM.
  assign reserved   = {1'b0, count_q} + RES_W'(inflight_q) + RES_W'(1);
  assign has_space  = reserved <= RES_W'(FIFO_DEPTH);
  assign issue      = (state_q == RUN) && (remaining_q != '0) && has_space;
  assign last_issue = issue && (remaining_q == (ADDR_W+1)'(1));

  assign push    = inflight_q;
  assign pop     = st_valid && st_ready;
  assign eop_pop = pop && st_eop;

  // NOTE: always_comb assigns every output a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_start) state_d = RUN;
      RUN:     if (last_issue)   state_d = DRAIN;
      DRAIN:   if (eop_pop)      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q      <= '0;
      remaining_q    <= '0;
      first_q        <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
      zero_done_q    <= 1'b0;
    end else begin
      inflight_q     <= issue;
      inflight_sop_q <= issue && first_q;
      inflight_eop_q <= last_issue;
      zero_done_q    <= zero_start;
      if (accept_start) begin
        rd_addr_q   <= base_addr;
        remaining_q <= word_count;
        first_q     <= 1'b1;
      end else if (issue) begin
        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - (ADDR_W+1)'(1);
        first_q     <= 1'b0;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is never read before it is
  // written because st_valid depends only on the reset occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{data: mem_readdata, sop: inflight_sop_q, eop: inflight_eop_q};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are gated by st_valid so the stream reads as zero when empty.
  assign head     = fifo_mem[rd_ptr_q];
  assign st_valid = (count_q != '0);
  assign st_data  = st_valid ? head.data : '0;
  assign st_sop   = st_valid && head.sop;
  assign st_eop   = st_valid && head.eop;

  assign busy = (state_q != IDLE);
  assign done = zero_done_q || ((state_q == DRAIN) && eop_pop);

  assign mem_address    = rd_addr_q;
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'b1111;

endmodule

// File: tb/tb_design01_mat_row_fetch.sv
// Directed bench for design01_mat_row_fetch: a table of fetches checked against
// hand-computed results, plus timing, wrap-around and mid-fetch reset sequences.
module tb_design01_mat_row_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic        busy;
  logic        done;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;

  design01_mat_row_fetch #(.ADDR_W(13), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop)
  );

  always #5 clk = ~clk;

  // RAM model: word i holds value i, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= {19'b0, mem_address};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-fetch observation record, filled by tick().
  logic [31:0] bdata[$];
  logic        bsop[$];
  logic        beop[$];
  int          bcyc[$];
  logic [12:0] addr_q[$];
  int cyc, n_reads, stall_reads, done_cnt, done_cyc, busy_cnt, stab_err;
  int first_cs, last_cs, first_valid;
  logic        hold_prev;
  logic [31:0] pdata;
  logic        psop, peop;

  task automatic clear_mon();
    bdata.delete(); bsop.delete(); beop.delete(); bcyc.delete(); addr_q.delete();
    cyc = 0; n_reads = 0; stall_reads = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; stab_err = 0; first_cs = -1; last_cs = -1; first_valid = -1;
    hold_prev = 1'b0; pdata = '0; psop = 1'b0; peop = 1'b0;
  endtask

  // Sample outputs on the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (mem_chipselect) begin
      addr_q.push_back(mem_address);
      if (first_cs < 0) first_cs = cyc;
      last_cs = cyc;
      n_reads++;
      if (!st_ready) stall_reads++;
    end
    if (st_valid && first_valid < 0) first_valid = cyc;
    if (st_valid && st_ready) begin
      bdata.push_back(st_data);
      bsop.push_back(st_sop);
      beop.push_back(st_eop);
      bcyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (hold_prev && (!st_valid || st_data !== pdata || st_sop !== psop || st_eop !== peop))
      stab_err++;
    hold_prev = st_valid && !st_ready;
    pdata = st_data;
    psop  = st_sop;
    peop  = st_eop;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One fetch: start in cycle 0, st_ready low for the first `stall` cycles,
  // optional extra start pulse at cycle `restart`; runs 3 cycles past done.
  task automatic run_fetch(input logic [12:0] b, input logic [13:0] n,
                           input int stall, input int restart);
    int extra;
    extra = 0;
    clear_mon();
    base_addr  = b;
    word_count = n;
    for (int c = 0; c < 400; c++) begin
      start = (c == 0) || (c == restart);
      if (c == restart) begin
        base_addr  = 13'h0800;
        word_count = 14'd2;
      end
      st_ready = (c >= stall);
      tick();
      if (done_cnt > 0) extra++;
      if (extra > 3) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [12:0] base;
    logic [13:0] count;
    int          stall;
    int          restart;
    int          exp_beats;
    int          exp_stall_reads;
    int          exp_busy;
    int          exp_done_cyc;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int errs;
    int nb;
    logic [12:0] ea;
    logic [12:0] wrap_addr [4];

    vecs[0] = '{13'h0010, 14'd4,  0,  -1, 4,  0, 6,  6};
    vecs[1] = '{13'h1FFE, 14'd4,  0,  -1, 4,  0, 6,  6};
    vecs[2] = '{13'h0100, 14'd1,  0,  -1, 1,  0, 3,  3};
    vecs[3] = '{13'h0200, 14'd16, 10, -1, 16, 4, 25, 25};
    vecs[4] = '{13'h0005, 14'd0,  0,  -1, 0,  0, 0,  1};
    vecs[5] = '{13'h0A00, 14'd3,  5,  -1, 3,  3, 7,  7};
    vecs[6] = '{13'h1F00, 14'd9,  0,  4,  9,  0, 11, 11};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    st_ready   = 1'b1;
    clear_mon();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_valid", st_valid, 0);
    check("rst_sop",   st_sop, 0);
    check("rst_eop",   st_eop, 0);
    check("rst_cs",    mem_chipselect, 0);
    check("rst_data",  st_data, 0);
    check("rst_addr",  mem_address, 0);
    check("tie_clken", mem_clken, 1);
    check("tie_write", mem_write, 0);
    check("tie_be",    mem_byteenable, 4'b1111);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < NV; v++) begin
      run_fetch(vecs[v].base, vecs[v].count, vecs[v].stall, vecs[v].restart);
      nb = bdata.size();
      check($sformatf("v%0d done_pulses", v), done_cnt, 1);
      check($sformatf("v%0d done_cycle", v), done_cyc, vecs[v].exp_done_cyc);
      check($sformatf("v%0d beats", v), nb, vecs[v].exp_beats);
      check($sformatf("v%0d reads", v), n_reads, vecs[v].exp_beats);
      check($sformatf("v%0d stall_reads", v), stall_reads, vecs[v].exp_stall_reads);
      check($sformatf("v%0d busy_cycles", v), busy_cnt, vecs[v].exp_busy);
      check($sformatf("v%0d stable_hold", v), stab_err, 0);
      errs = 0;
      for (int i = 0; i < nb; i++) begin
        ea = vecs[v].base + 13'(i);
        if (bdata[i] !== {19'b0, ea} || bsop[i] !== (i == 0) ||
            beop[i] !== (i == vecs[v].exp_beats - 1))
          errs++;
      end
      check($sformatf("v%0d order_sideband_errs", v), errs, 0);
    end

    // Exact cycle timing of a 4-word fetch with the sink always ready.
    run_fetch(13'h0010, 14'd4, 0, -1);
    check("t_first_cs",    first_cs, 1);
    check("t_last_cs",     last_cs, 4);
    check("t_first_valid", first_valid, 3);
    check("t_beat0_cyc",   (bcyc.size() == 4) ? bcyc[0] : -1, 3);
    check("t_beat3_cyc",   (bcyc.size() == 4) ? bcyc[3] : -1, 6);
    check("t_done_cyc",    done_cyc, 6);

    // Address wrap at the top of the RAM.
    wrap_addr[0] = 13'h1FFE;
    wrap_addr[1] = 13'h1FFF;
    wrap_addr[2] = 13'h0000;
    wrap_addr[3] = 13'h0001;
    run_fetch(13'h1FFE, 14'd4, 0, -1);
    check("wrap_nreads", addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_addr%0d", i), (addr_q.size() > i) ? addr_q[i] : 13'h1ABC, wrap_addr[i]);

    // Reset after the third beat of an 8-word fetch.
    clear_mon();
    base_addr  = 13'h0300;
    word_count = 14'd8;
    st_ready   = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && bdata.size() < 3; c++) tick();
    check("mr_beats_before", bdata.size(), 3);
    reset_n = 1'b0;
    #1;
    check("mr_busy",  busy, 0);
    check("mr_done",  done, 0);
    check("mr_valid", st_valid, 0);
    check("mr_sop",   st_sop, 0);
    check("mr_eop",   st_eop, 0);
    check("mr_cs",    mem_chipselect, 0);
    check("mr_data",  st_data, 0);
    check("mr_addr",  mem_address, 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_mon();
    for (int c = 0; c < 6; c++) tick();
    check("mr_no_stale_beat",  bdata.size(), 0);
    check("mr_no_stale_valid", first_valid, -1);
    check("mr_no_reads",       n_reads, 0);
    run_fetch(13'h0000, 14'd2, 0, -1);
    check("mr_new_beats", bdata.size(), 2);
    check("mr_new_d0",    (bdata.size() > 0) ? bdata[0] : 32'hDEAD, 32'h0);
    check("mr_new_d1",    (bdata.size() > 1) ? bdata[1] : 32'hDEAD, 32'h1);
    check("mr_new_sop0",  (bsop.size() > 0) ? bsop[0] : 1'b0, 1);
    check("mr_new_sop1",  (bsop.size() > 1) ? bsop[1] : 1'b1, 0);
    check("mr_new_eop1",  (beop.size() > 1) ? beop[1] : 1'b0, 1);
    check("mr_new_done",  done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/design01_mat_row_fetch.md
DESIGN01_MAT_ROW_FETCH -- requirements
Module: design01_mat_row_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: word-address width of the on-chip RAM port.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth in words, power of two, minimum 2.
REQ-003 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1: one-cycle request to begin a fetch.
REQ-006 SHALL have port base_addr  in  ADDR_W: first word address, sampled with start.
REQ-007 SHALL have port word_count  in  ADDR_W+1: number of words to fetch, sampled with start.
REQ-008 SHALL have port busy  out  1: high from accepted start until the last word leaves the stream.
REQ-009 SHALL have port done  out  1: one-cycle pulse at completion.
REQ-010 SHALL have port mem_address  out  ADDR_W: RAM word address.
REQ-011 SHALL have port mem_chipselect  out  1: RAM select.
REQ-012 SHALL have port mem_clken  out  1: RAM clock enable, tied high.
REQ-013 SHALL have port mem_write  out  1: tied low; the block never writes.
REQ-014 SHALL have port mem_byteenable  out  4: tied 4'b1111.
REQ-015 SHALL have port mem_readdata  in  32: RAM data, valid exactly one cycle after the address is presented with chipselect high.
REQ-016 SHALL have port st_data  out  32: stream data.
REQ-017 SHALL have port st_valid  out  1: stream data valid.
REQ-018 SHALL have port st_ready  in  1: sink accepts when valid && ready.
REQ-019 SHALL have ports st_sop and st_eop  out  1 each: first and last word of a fetch.

Function
REQ-020 SHALL implement states IDLE, RUN and DRAIN.
- IDLE -> RUN on start with word_count != 0.
- RUN -> DRAIN after the last read is issued.
- DRAIN -> IDLE when the eop word is accepted; done pulses in that same cycle.
REQ-021 start with word_count == 0 SHALL produce a done pulse on the next cycle, with no RAM access and no stream beat.
REQ-022 start while busy SHALL be ignored, with no effect on the current fetch.
REQ-023 A read SHALL be issued (mem_chipselect=1) only in RUN and only when buffered words + in-flight reads + 1 <= FIFO_DEPTH; the FIFO SHALL never overflow.
REQ-024 With st_ready held high, reads SHALL issue back-to-back, giving one beat per cycle.
REQ-025 Throughput SHALL be sustained: the first st_valid rises 2 cycles after start is sampled (issue cycle, then capture cycle).
REQ-026 The read address SHALL increment by 1 per issued read, modulo 2^ADDR_W: 8191 wraps to 0.
REQ-027 The remaining-count register SHALL be ADDR_W+1 bits, so word_count = 2^ADDR_W is legal.
REQ-028 mem_readdata SHALL be written into the FIFO one cycle after each issued read, unconditionally; space for it is already reserved by REQ-023.
REQ-029 The FIFO SHALL be first-word-fall-through.
- st_valid = not empty.
- st_data, st_sop and st_eop come from the head entry.
REQ-030 On the same cycle, push and pop SHALL be handled together: occupancy is unchanged, and both entries are handled correctly even when the FIFO is empty or full.
REQ-031 Sideband bits SHALL be stored with each word: sop for the first word of a fetch, eop for the last; a 1-word fetch has both set.
REQ-032 While st_valid is high and st_ready is low, st_data, st_sop and st_eop SHALL hold stable.
REQ-033 mem_address SHALL be driven only with the issue address while chipselect is high; otherwise its value is don't-care.

Reset
REQ-034 Asserting reset_n low SHALL, asynchronously:
- force state = IDLE;
- set busy=0, done=0, st_valid=0, st_sop=0, st_eop=0, mem_chipselect=0;
- clear FIFO pointers, occupancy, in-flight flag and counters.
REQ-035 Reset mid-fetch SHALL discard all buffered and in-flight data; no stale beat SHALL appear after reset is released.
REQ-036 st_data and mem_address SHALL reset to 0.

Verification
REQ-037 base=0x0010, count=4, st_ready=1, RAM[i]=i -> chipselect high for cycles 1-4, data 0x10..0x13 on consecutive cycles, sop on 0x10, eop on 0x13, a single done pulse with the eop beat.
REQ-038 base=0x1FFE, count=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 in that order.
REQ-039 count=16, FIFO_DEPTH=4, st_ready low for 10 cycles after start -> at most 4 reads issued and no data lost; after release, 16 beats in order with one eop.
REQ-040 count=0 -> done one cycle later, busy never high, zero beats; also: start pulsed during a fetch -> ignored.
REQ-041 count=1 -> a single beat with sop=eop=1 and done asserted with it.
REQ-042 reset_n low after the 3rd beat of count=8, then release -> outputs at reset values; a new start base=0 count=2 gives exactly 2 beats with a clean sop.
